// File: rtl/writeback_arbiter_if.sv
// Write-back request/response bundle shared by the ALU path, the load path
// and the register-file write port. Requesters use the master modport, the
// arbiter uses the slave modport.
interface writeback_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // ALU write-back request
  logic                      aluValid;
  logic                      aluReady;
  logic [REG_ADDR_WIDTH-1:0] aluReg;
  logic [DATA_WIDTH-1:0]     result;
  // Load write-back request
  logic                      memValid;
  logic                      memReady;
  logic [REG_ADDR_WIDTH-1:0] memReg;
  logic [DATA_WIDTH-1:0]     readData;
  // Register-file write port and status
  logic                      regWrite;
  logic [REG_ADDR_WIDTH-1:0] writeReg;
  logic [DATA_WIDTH-1:0]     writeData;
  logic                      memToReg;
  logic                      aluStalled;

  modport master (
    output aluValid, aluReg, result, memValid, memReg, readData,
    input  aluReady, memReady, regWrite, writeReg, writeData, memToReg, aluStalled
  );

  modport slave (
    input  aluValid, aluReg, result, memValid, memReg, readData,
    output aluReady, memReady, regWrite, writeReg, writeData, memToReg, aluStalled
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-file write port between the ALU result path
// and the load return path. Loads win by default; an ALU request that has been
// held off for MAX_WAIT cycles is forced through for one cycle. The winning
// write is registered (one cycle latency) together with memToReg so the
// downstream write-back mux picks the right source.
module writeback_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_WAIT       = 3
) (
  input logic                clk,
  input logic                resetN,
  writeback_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic                      force_alu_s;
  logic                      mem_ready_s;
  logic                      alu_ready_s;

  logic [3:0]                wait_cnt_d;
  logic [3:0]                wait_cnt_q;
  logic                      reg_write_d;
  logic                      reg_write_q;
  logic [REG_ADDR_WIDTH-1:0] write_reg_d;
  logic [REG_ADDR_WIDTH-1:0] write_reg_q;
  logic [DATA_WIDTH-1:0]     write_data_d;
  logic [DATA_WIDTH-1:0]     write_data_q;
  logic                      mem_to_reg_d;
  logic                      mem_to_reg_q;

  // Grant decision: memory priority unless the ALU has exhausted its wait budget;
  // no grant at all while reset is asserted.
  always_comb begin
    force_alu_s = bus.aluValid && (wait_cnt_q == MAX_WAIT_C);
    mem_ready_s = 1'b0;
    alu_ready_s = 1'b0;
    if (!resetN) begin
      mem_ready_s = 1'b0;
      alu_ready_s = 1'b0;
    end else begin
      mem_ready_s = bus.memValid && !force_alu_s;
      alu_ready_s = bus.aluValid && !mem_ready_s;
    end
  end

  // Starvation counter: counts consecutive stalled ALU cycles, saturating at the
  // budget, and restarts whenever the ALU request is taken or withdrawn.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.aluValid || alu_ready_s) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = MAX_WAIT_C;
    end
  end

  // Next write-port contents: capture the winner; register 0 is accepted but
  // never enabled; idle cycles drop the enable and keep the last payload.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    mem_to_reg_d = mem_to_reg_q;
    if (mem_ready_s) begin
      reg_write_d  = (bus.memReg != {REG_ADDR_WIDTH{1'b0}});
      write_reg_d  = bus.memReg;
      write_data_d = bus.readData;
      mem_to_reg_d = 1'b1;
    end else if (alu_ready_s) begin
      reg_write_d  = (bus.aluReg != {REG_ADDR_WIDTH{1'b0}});
      write_reg_d  = bus.aluReg;
      write_data_d = bus.result;
      mem_to_reg_d = 1'b0;
    end else begin
      reg_write_d  = 1'b0;
    end
  end

  // State and output registers; asynchronous reset discards any pending write.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wait_cnt_q   <= 4'd0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= {REG_ADDR_WIDTH{1'b0}};
      write_data_q <= {DATA_WIDTH{1'b0}};
      mem_to_reg_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign bus.aluReady   = alu_ready_s;
  assign bus.memReady   = mem_ready_s;
  assign bus.aluStalled = bus.aluValid && !alu_ready_s;
  assign bus.regWrite   = reg_write_q;
  assign bus.writeReg   = write_reg_q;
  assign bus.writeData  = write_data_q;
  assign bus.memToReg   = mem_to_reg_q;

endmodule
